// File: rtl/fsm_result_collector_pkg.sv
// -----------------------------------------------------------------------------
// fsm_result_collector_pkg
//   Shared types and sizing helpers for the result collector.
//   - collector_state_t : burst-assembly FSM states
//   - beats_of / cnt_w_of : beat count and beat-counter width, derived from the
//     word width and nibble width (same arithmetic as fsm_design's byte count)
//   - BEATS / CNT_W : values for the default N=64, N_width=4 configuration
// -----------------------------------------------------------------------------
package fsm_result_collector_pkg;

  typedef enum logic [0:0] {
    C_IDLE    = 1'b0,
    C_COLLECT = 1'b1
  } collector_state_t;

  localparam int DEF_N       = 64;
  localparam int DEF_N_WIDTH = 4;
  localparam int DEF_DEPTH   = 2;

  // Number of nibble beats that make one result word.
  function automatic int beats_of(input int n, input int w);
    return n / w;
  endfunction

  // Width of a counter that indexes 0..beats-1 (at least one bit).
  function automatic int cnt_w_of(input int beats);
    return (beats > 1) ? $clog2(beats) : 1;
  endfunction

  localparam int BEATS = beats_of(DEF_N, DEF_N_WIDTH);
  localparam int CNT_W = cnt_w_of(BEATS);

endpackage

// File: rtl/fsm_result_collector_if.sv
// -----------------------------------------------------------------------------
// fsm_result_collector_if
//   Groups the collector's two data paths:
//   - beat stream in : in_valid, in_nibble (from fsm_design output_valid/out)
//   - result stream  : res_valid, res_ready, res_data, res_level
//   modport slave  : the collector (consumes beats, produces results)
//   modport master : the environment (produces beats, consumes results)
// -----------------------------------------------------------------------------
interface fsm_result_collector_if #(
  parameter int N       = 64,
  parameter int N_width = 4,
  parameter int DEPTH   = 2
);

  localparam int LW = $clog2(DEPTH) + 1;

  logic               in_valid;
  logic [N_width-1:0] in_nibble;
  logic               res_valid;
  logic               res_ready;
  logic [N-1:0]       res_data;
  logic [LW-1:0]      res_level;

  modport slave (
    input  in_valid,
    input  in_nibble,
    input  res_ready,
    output res_valid,
    output res_data,
    output res_level
  );

  modport master (
    output in_valid,
    output in_nibble,
    output res_ready,
    input  res_valid,
    input  res_data,
    input  res_level
  );

endinterface

// File: rtl/fsm_result_collector_result_fifo.sv
// -----------------------------------------------------------------------------
// result_fifo
//   Synchronous FIFO holding assembled result words.
//   Ports:
//     clk, rst    clock, asynchronous active-low reset
//     push        write request; accepted when not full, or when full with a
//                 pop in the same cycle
//     push_data   word to write
//     pop         read request; honoured only when not empty
//     rd_data     head word (zero while empty, so nothing stale is visible)
//     full, empty occupancy flags
//     level       occupancy, 0..DEPTH
//     ovf         push refused this cycle (full and no pop)
//   No bypass: a word pushed into an empty FIFO becomes visible next cycle.
// -----------------------------------------------------------------------------
module result_fifo #(
  parameter int W     = 64,
  parameter int DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [W-1:0]             push_data,
  input  logic                     pop,
  output logic [W-1:0]             rd_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     ovf
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int LW = $clog2(DEPTH) + 1;

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_q;
  logic [AW-1:0] rd_q;
  logic [LW-1:0] level_q;
  logic          do_push;
  logic          do_pop;

  assign full    = (level_q == LW'(DEPTH));
  assign empty   = (level_q == '0);
  assign do_pop  = pop && !empty;
  // When full, a simultaneous pop frees the slot the write lands in
  // (wr_q == rd_q), and the head is read before the edge overwrites it.
  assign do_push = push && (!full || do_pop);
  assign ovf     = push && full && !do_pop;

  // DEPTH is a power of two, so pointers wrap naturally at AW bits.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_q    <= '0;
      rd_q    <= '0;
      level_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + AW'(1);
      if (do_pop)  rd_q <= rd_q + AW'(1);
      case ({do_push, do_pop})
        2'b10:   level_q <= level_q + LW'(1);
        2'b01:   level_q <= level_q - LW'(1);
        default: level_q <= level_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_q] <= push_data;
  end

  assign rd_data = empty ? '0 : mem[rd_q];
  assign level   = level_q;

endmodule

// File: rtl/fsm_result_collector.sv
// -----------------------------------------------------------------------------
// fsm_result_collector
//   Reassembles fsm_design's nibble-serial output burst into N-bit words and
//   queues them for a valid/ready consumer.
//   Ports:
//     clk        clock (posedge)
//     rst        asynchronous active-low reset
//     bus        fsm_result_collector_if.slave
//                  in_valid/in_nibble  beat stream, LSB nibble first
//                  res_valid/res_ready/res_data  head word handshake
//                  res_level           FIFO occupancy
//     clr_flags  synchronous clear of the sticky error flags
//     busy       a burst is partially assembled
//     err_short  sticky: burst ended before all beats arrived
//     err_ovf    sticky: completed word dropped because the FIFO was full
// -----------------------------------------------------------------------------
module fsm_result_collector
  import fsm_result_collector_pkg::*;
#(
  parameter int N       = 64,
  parameter int N_width = 4,
  parameter int DEPTH   = 2
) (
  input  logic                        clk,
  input  logic                        rst,
  fsm_result_collector_if.slave       bus,
  input  logic                        clr_flags,
  output logic                        busy,
  output logic                        err_short,
  output logic                        err_ovf
);

  localparam int NUM_BEATS = beats_of(N, N_width);
  localparam int CNT_BITS  = cnt_w_of(NUM_BEATS);
  localparam int LW        = $clog2(DEPTH) + 1;

  collector_state_t state_q, state_d;
  logic [CNT_BITS-1:0] cnt_q, cnt_d;
  logic [N-1:0]        asm_q, asm_d;
  logic [N-1:0]        word;
  logic                push;
  logic                short_evt;
  logic                pop;
  logic                fifo_full;
  logic                fifo_empty;
  logic                fifo_ovf;
  logic [N-1:0]        fifo_rd_data;
  logic [LW-1:0]       fifo_level;

  // Assembly FSM state
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= C_IDLE;
      cnt_q   <= '0;
      asm_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      asm_q   <= asm_d;
    end
  end

  // Next state, beat placement, push and abort detection
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    asm_d     = asm_q;
    word      = asm_q;
    push      = 1'b0;
    short_evt = 1'b0;
    case (state_q)
      C_IDLE: begin
        if (bus.in_valid) begin
          asm_d                = '0;
          asm_d[N_width-1:0]   = bus.in_nibble;
          cnt_d                = CNT_BITS'(1);
          state_d              = C_COLLECT;
        end
      end
      C_COLLECT: begin
        if (bus.in_valid) begin
          word[int'(cnt_q)*N_width +: N_width] = bus.in_nibble;
          if (cnt_q == CNT_BITS'(NUM_BEATS - 1)) begin
            // Final beat: hand the full word to the FIFO and clear the
            // assembly register so no bits carry into the next burst.
            push    = 1'b1;
            asm_d   = '0;
            cnt_d   = '0;
            state_d = C_IDLE;
          end else begin
            asm_d = word;
            cnt_d = cnt_q + CNT_BITS'(1);
          end
        end else begin
          // Burst dropped out early: the partial word is discarded.
          short_evt = 1'b1;
          asm_d     = '0;
          cnt_d     = '0;
          state_d   = C_IDLE;
        end
      end
      default: begin
        state_d = C_IDLE;
        cnt_d   = '0;
        asm_d   = '0;
      end
    endcase
  end

  assign pop = bus.res_valid && bus.res_ready;

  result_fifo #(
    .W     (N),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (word),
    .pop       (pop),
    .rd_data   (fifo_rd_data),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .level     (fifo_level),
    .ovf       (fifo_ovf)
  );

  // Sticky error flags; a new event in the same cycle beats the clear.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      err_short <= 1'b0;
      err_ovf   <= 1'b0;
    end else begin
      if (short_evt)      err_short <= 1'b1;
      else if (clr_flags) err_short <= 1'b0;
      if (fifo_ovf)       err_ovf   <= 1'b1;
      else if (clr_flags) err_ovf   <= 1'b0;
    end
  end

  assign bus.res_valid = !fifo_empty;
  assign bus.res_data  = fifo_rd_data;
  assign bus.res_level = fifo_level;
  assign busy          = (state_q == C_COLLECT);

endmodule

// File: tb/tb_fsm_result_collector.sv
// -----------------------------------------------------------------------------
// tb_fsm_result_collector
//   Scoreboard bench for fsm_result_collector (N=64, N_width=4, DEPTH=2).
//   Expected words are queued when their final beat is driven and compared
//   when the DUT hands them out through res_valid/res_ready.
// -----------------------------------------------------------------------------
module tb_fsm_result_collector;

  localparam int N       = 64;
  localparam int N_width = 4;
  localparam int DEPTH   = 2;

  logic clk;
  logic rst;
  logic clr_flags;
  logic busy;
  logic err_short;
  logic err_ovf;

  int checks;
  int failures;
  logic [N-1:0] exp_q[$];

  fsm_result_collector_if #(.N(N), .N_width(N_width), .DEPTH(DEPTH)) bus ();

  fsm_result_collector #(
    .N       (N),
    .N_width (N_width),
    .DEPTH   (DEPTH)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .clr_flags (clr_flags),
    .busy      (busy),
    .err_short (err_short),
    .err_ovf   (err_ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [N-1:0] obs, input logic [N-1:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Inputs change 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input logic v, input logic [N_width-1:0] nib);
    tick();
    bus.in_valid  = v;
    bus.in_nibble = nib;
  endtask

  // Drives all 16 beats of one word, LSB nibble first; the caller ends the
  // burst. expect_push queues the word for the scoreboard; ready_on_last
  // raises res_ready together with the final beat.
  task automatic burst(input logic [N-1:0] w, input bit expect_push, input bit ready_on_last);
    for (int i = 0; i < N / N_width; i++) begin
      beat(1'b1, w[i*N_width +: N_width]);
      if (i == N / N_width - 1 && ready_on_last) bus.res_ready = 1'b1;
    end
    if (expect_push) exp_q.push_back(w);
  endtask

  // Scoreboard: a word leaves the DUT on every edge where valid && ready.
  always @(negedge clk) begin
    if (rst && bus.res_valid && bus.res_ready) begin
      if (exp_q.size() == 0) chk("sb_unexpected_word", bus.res_data, '0);
      else chk("sb_word", bus.res_data, exp_q.pop_front());
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    checks        = 0;
    failures      = 0;
    rst           = 1'b0;
    clr_flags     = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_nibble = '0;
    bus.res_ready = 1'b0;
    tick();
    tick();
    chk("rst_res_valid", bus.res_valid, 0);
    chk("rst_res_data",  bus.res_data,  0);
    chk("rst_level",     bus.res_level, 0);
    chk("rst_busy",      busy,          0);
    chk("rst_err_short", err_short,     0);
    chk("rst_err_ovf",   err_ovf,       0);
    rst = 1'b1;
    tick();

    // 1: single word 0..F, latency 1
    bus.res_ready = 1'b1;
    burst(64'hFEDCBA9876543210, 1'b1, 1'b0);
    chk("t1_valid_before_last", bus.res_valid, 0);
    chk("t1_busy", busy, 1);
    beat(1'b0, 4'h0);
    chk("t1_valid_after_last", bus.res_valid, 1);
    chk("t1_level", bus.res_level, 1);
    chk("t1_busy_idle", busy, 0);
    tick();
    chk("t1_popped", bus.res_valid, 0);
    chk("t1_err_short", err_short, 0);
    chk("t1_err_ovf", err_ovf, 0);

    // 2: short burst, clear, then full burst of A
    for (int i = 0; i < 7; i++) beat(1'b1, 4'h5);
    beat(1'b0, 4'h0);
    tick();
    chk("t2_err_short", err_short, 1);
    chk("t2_no_word", bus.res_valid, 0);
    chk("t2_busy", busy, 0);
    clr_flags = 1'b1;
    tick();
    clr_flags = 1'b0;
    chk("t2_cleared", err_short, 0);
    burst(64'hAAAAAAAAAAAAAAAA, 1'b1, 1'b0);
    beat(1'b0, 4'h0);
    tick();
    tick();
    chk("t2_drained", bus.res_level, 0);

    // 3: overflow with consumer stalled
    bus.res_ready = 1'b0;
    burst(64'h1111111111111111, 1'b1, 1'b0);
    beat(1'b0, 4'h0);
    burst(64'h2222222222222222, 1'b1, 1'b0);
    beat(1'b0, 4'h0);
    burst(64'h3333333333333333, 1'b0, 1'b0);
    beat(1'b0, 4'h0);
    tick();
    chk("t3_level", bus.res_level, 2);
    chk("t3_err_ovf", err_ovf, 1);
    chk("t3_head_stable", bus.res_data, 64'h1111111111111111);
    bus.res_ready = 1'b1;
    tick();
    tick();
    bus.res_ready = 1'b0;
    chk("t3_empty", bus.res_level, 0);
    clr_flags = 1'b1;
    tick();
    clr_flags = 1'b0;
    chk("t3_ovf_cleared", err_ovf, 0);

    // 4: full FIFO, final beat coincides with a pop
    burst(64'h4444444444444444, 1'b1, 1'b0);
    beat(1'b0, 4'h0);
    burst(64'h5555555555555555, 1'b1, 1'b0);
    beat(1'b0, 4'h0);
    tick();
    chk("t4_full", bus.res_level, 2);
    burst(64'h6666666666666666, 1'b1, 1'b1);
    beat(1'b0, 4'h0);
    bus.res_ready = 1'b0;
    chk("t4_level", bus.res_level, 2);
    chk("t4_no_ovf", err_ovf, 0);
    chk("t4_head", bus.res_data, 64'h5555555555555555);
    bus.res_ready = 1'b1;
    tick();
    tick();
    bus.res_ready = 1'b0;
    chk("t4_drained", bus.res_level, 0);

    // 5: in_valid held high across two bursts
    bus.res_ready = 1'b1;
    burst(64'hFEDCBA9876543210, 1'b1, 1'b0);
    burst(64'hFEDCBA9876543210, 1'b1, 1'b0);
    beat(1'b0, 4'h0);
    tick();
    tick();
    chk("t5_err_short", err_short, 0);
    chk("t5_drained", bus.res_level, 0);

    // 6: reset mid-burst with one word queued
    bus.res_ready = 1'b0;
    burst(64'h7777777777777777, 1'b0, 1'b0);
    beat(1'b0, 4'h0);
    for (int i = 0; i < 9; i++) beat(1'b1, 4'h8);
    rst = 1'b0;
    bus.in_valid = 1'b0;
    #1;
    chk("t6_res_valid", bus.res_valid, 0);
    chk("t6_res_data",  bus.res_data,  0);
    chk("t6_level",     bus.res_level, 0);
    chk("t6_busy",      busy,          0);
    chk("t6_err_short", err_short,     0);
    chk("t6_err_ovf",   err_ovf,       0);
    tick();
    rst = 1'b1;
    tick();
    bus.res_ready = 1'b1;
    burst(64'h0123456789ABCDEF, 1'b1, 1'b0);
    beat(1'b0, 4'h0);
    tick();
    tick();
    chk("t6_post_rst_drained", bus.res_level, 0);

    chk("sb_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
